// File: rtl/bg_scroll_ctrl.sv
// Background scroll controller: advances the fine x_offset once per frame and,
// on each 16-pixel carry, shifts the playfield rows of the tile map left by one
// column during vblank, writing a fresh tile column at the right edge.
// HUD rows above ROW_FIRST are never touched.
// Optional feature macro: BG_SCROLL_LFSR_EN (random obstacle column from a
// 16-bit LFSR instead of the constant FILL_TILE word).
module bg_scroll_ctrl #(
  parameter int          TILE_COLS = 40,
  parameter int          TILE_ROWS = 30,
  parameter int          ROW_FIRST = 5,
  parameter logic [15:0] FILL_TILE = 16'h0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        game_over,
  input  logic [3:0]  speed,
  input  logic [15:0] ram_rd_data,
  output logic        ram_req,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wr_data,
  output logic [3:0]  x_offset,
  output logic        scroll_done,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

  localparam logic [15:0] COLS_W     = 16'(TILE_COLS);
  localparam logic [15:0] LAST_COL   = 16'(TILE_COLS - 2);
  localparam logic [15:0] EDGE_COL   = 16'(TILE_COLS - 1);
  localparam logic [15:0] LAST_ROW   = 16'(TILE_ROWS - 1);
  localparam logic [15:0] FIRST_ROW  = 16'(ROW_FIRST);
  localparam logic [15:0] FIRST_BASE = 16'(ROW_FIRST * TILE_COLS);

  state_t      state, state_nx;
  logic [15:0] row;
  logic [15:0] row_base;   // row * TILE_COLS, kept incrementally
  logic [15:0] col;
  logic [3:0]  sum_lo;     // fine offset to apply once the shift completes
  logic [4:0]  sum_now;
  logic        start;
  logic [15:0] new_tile;

  assign sum_now = {1'b0, x_offset} + {1'b0, speed};
  assign start   = (state == IDLE) && frame_tick && !game_over;

`ifdef BG_SCROLL_LFSR_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Map the LFSR state onto a tile word; lfsr[0] acts as the ENABLE bit
  function automatic logic [15:0] tile_from_lfsr(input logic [15:0] l);
    return {7'b0, l[0], 2'b00, l[3:1], l[6:4]};
  endfunction

  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign new_tile = tile_from_lfsr(lfsr);

  // Fibonacci LFSR, advanced once per right-edge column write
  always_ff @(posedge clk) begin
    if (reset)
      lfsr <= 16'hACE1;
    else if (state == FILL)
      lfsr <= {lfsr[14:0], lfsr_fb};
  end
`else
  assign new_tile = FILL_TILE;
`endif

  // State register; reset aborts any shift in progress immediately
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state and RAM port decode
  always_comb begin
    state_nx    = state;
    ram_req     = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = 16'd0;
    ram_wr_data = 16'd0;
    scroll_done = 1'b0;
    case (state)
      IDLE: begin
        if (start && sum_now[4])
          state_nx = RD;
      end
      RD: begin
        ram_req  = 1'b1;
        ram_addr = row_base + col + 16'd1;
        state_nx = WR;
      end
      WR: begin
        ram_req     = 1'b1;
        ram_we      = 1'b1;
        ram_addr    = row_base + col;
        ram_wr_data = ram_rd_data;
        state_nx    = (col == LAST_COL) ? FILL : RD;
      end
      FILL: begin
        ram_req     = 1'b1;
        ram_we      = 1'b1;
        ram_addr    = row_base + EDGE_COL;
        ram_wr_data = new_tile;
        state_nx    = (row == LAST_ROW) ? DONE : RD;
      end
      DONE: begin
        scroll_done = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Row/column walk; always re-initialised on a shift start, so no reset needed
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          sum_lo   <= sum_now[3:0];
          row      <= FIRST_ROW;
          row_base <= FIRST_BASE;
          col      <= 16'd0;
        end
      end
      WR: begin
        if (col != LAST_COL)
          col <= col + 16'd1;
      end
      FILL: begin
        row      <= row + 16'd1;
        row_base <= row_base + COLS_W;
        col      <= 16'd0;
      end
      default: ;
    endcase
  end

  // Fine offset updates only when the coarse map is consistent; sticky overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      x_offset <= 4'd0;
      overrun  <= 1'b0;
    end else begin
      if (start && !sum_now[4])
        x_offset <= sum_now[3:0];
      else if (state == DONE)
        x_offset <= sum_lo;
      if (frame_tick && (state != IDLE))
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// Directed bench for bg_scroll_ctrl with a behavioural tile-map RAM model
// (one-cycle read latency, synchronous write).
module tb_bg_scroll_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        game_over = 1'b0;
  logic [3:0]  speed = 4'd0;
  logic [15:0] ram_rd_data = 16'd0;
  logic        ram_req;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wr_data;
  logic [3:0]  x_offset;
  logic        scroll_done;
  logic        overrun;

  logic [15:0] mem [0:1199];
  int          req_cnt = 0;
  int          we_cnt = 0;
  int          done_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  bg_scroll_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_over(game_over),
    .speed(speed), .ram_rd_data(ram_rd_data), .ram_req(ram_req),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wr_data(ram_wr_data),
    .x_offset(x_offset), .scroll_done(scroll_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Tile-map RAM: read data valid one cycle after the address
  always @(posedge clk) begin
    if (ram_we && ram_addr < 16'd1200)
      mem[ram_addr] <= ram_wr_data;
    ram_rd_data <= (ram_addr < 16'd1200) ? mem[ram_addr] : 16'hDEAD;
  end

  // Activity counters sampled mid-cycle
  always @(negedge clk) begin
    if (ram_req)     req_cnt  <= req_cnt + 1;
    if (ram_we)      we_cnt   <= we_cnt + 1;
    if (scroll_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick(input logic [3:0] spd);
    @(posedge clk); #1;
    speed = spd;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (scroll_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int r0, w0, d0;
    int hud_bad, body_bad, fill_bad;
    logic [15:0] keep;
    logic seen;

    for (int i = 0; i < 1200; i++) mem[i] = 16'(i);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", {31'd0, ram_req}, 0);
    check("rst_we", {31'd0, ram_we}, 0);
    check("rst_addr", {16'd0, ram_addr}, 0);
    check("rst_wdata", {16'd0, ram_wr_data}, 0);
    check("rst_xoff", {28'd0, x_offset}, 0);
    check("rst_done", {31'd0, scroll_done}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    reset = 1'b0;

    // 1: accumulate without carry
    r0 = req_cnt;
    tick(3); check("t1_x3", {28'd0, x_offset}, 3);
    tick(3); check("t1_x6", {28'd0, x_offset}, 6);
    tick(3); check("t1_x9", {28'd0, x_offset}, 9);
    tick(3); check("t1_x12", {28'd0, x_offset}, 12);
    tick(3); check("t1_x15", {28'd0, x_offset}, 15);
    repeat (3) @(posedge clk);
    check("t1_no_req", 32'(req_cnt - r0), 0);

    // speed 0: nothing moves
    tick(0);
    repeat (3) @(posedge clk);
    #1;
    check("spd0_x", {28'd0, x_offset}, 15);
    check("spd0_no_req", 32'(req_cnt - r0), 0);

    // 2: reach 14, then carry with speed 4
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    tick(14);
    check("t2_x14", {28'd0, x_offset}, 14);
    r0 = req_cnt; w0 = we_cnt; d0 = done_cnt;
    tick(4);
    check("t2_x_hold_mid", {28'd0, x_offset}, 14);
    wait_done("t2_done_seen");
    check("t2_x2", {28'd0, x_offset}, 2);
    repeat (5) @(posedge clk);
    #1;
    check("t2_req_cycles", 32'(req_cnt - r0), 1975);
    check("t2_writes", 32'(we_cnt - w0), 1000);
    check("t2_done_pulses", 32'(done_cnt - d0), 1);
    check("t2_req_idle", {31'd0, ram_req}, 0);

    // 3: map contents after one shift
    hud_bad = 0; body_bad = 0; fill_bad = 0;
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 40; c++) begin
        if (r < 5) begin
          if (mem[r*40+c] !== 16'(r*40+c)) hud_bad++;
        end else if (c < 39) begin
          if (mem[r*40+c] !== 16'(r*40+c+1)) body_bad++;
        end else begin
          if (mem[r*40+c] !== 16'h0100) fill_bad++;
        end
      end
    end
    check("t3_hud_bad", 32'(hud_bad), 0);
    check("t3_body_bad", 32'(body_bad), 0);
    check("t3_fill_bad", 32'(fill_bad), 0);
    check("t3_w200", {16'd0, mem[200]}, 201);
    check("t3_w1198", {16'd0, mem[1198]}, 1199);
    check("t3_w239", {16'd0, mem[239]}, 16'h0100);

    // 4: tick during a shift sets overrun, no second shift
    r0 = req_cnt; d0 = done_cnt;
    tick(15);
    repeat (100) @(posedge clk);
    tick(3);
    check("t4_overrun", {31'd0, overrun}, 1);
    check("t4_busy", {31'd0, ram_req}, 1);
    wait_done("t4_done_seen");
    check("t4_x1", {28'd0, x_offset}, 1);
    repeat (50) @(posedge clk);
    #1;
    check("t4_req_cycles", 32'(req_cnt - r0), 1975);
    check("t4_done_pulses", 32'(done_cnt - d0), 1);
    check("t4_overrun_sticky", {31'd0, overrun}, 1);

    // 5: game_over freezes
    keep = mem[200];
    r0 = req_cnt;
    game_over = 1'b1;
    tick(7);
    repeat (5) @(posedge clk);
    #1;
    check("t5_x_hold", {28'd0, x_offset}, 1);
    check("t5_no_req", 32'(req_cnt - r0), 0);
    check("t5_ram_hold", {16'd0, mem[200]}, {16'd0, keep});
    game_over = 1'b0;

    // 6: reset in the middle of a shift
    tick(15);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ram_req) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("t6_started", {31'd0, seen}, 1);
    repeat (500) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("t6_we", {31'd0, ram_we}, 0);
    check("t6_req", {31'd0, ram_req}, 0);
    check("t6_x0", {28'd0, x_offset}, 0);
    check("t6_overrun_clr", {31'd0, overrun}, 0);
    reset = 1'b0;
    r0 = req_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("t6_stays_idle", 32'(req_cnt - r0), 0);
    tick(1);
    check("t6_x1", {28'd0, x_offset}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
